// File: rtl/game_pkg.sv
// Shared types and constants for the pong score controller.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAUSE = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [6:0] ASCII_ZERO = 7'h30;

  // ASCII digit for a single-digit score.
  function automatic logic [6:0] digit_char(input logic [3:0] score);
    return ASCII_ZERO + {3'b000, score};
  endfunction

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector: one-cycle tick when sig goes high.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic tick
);

  logic r_sig;

  // Remember last cycle's level of sig.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sig <= 1'b0;
    end else begin
      r_sig <= sig;
    end
  end

  assign tick = sig & ~r_sig;

endmodule

// File: rtl/score_ctl.sv
// Match sequencer and score keeper for pong; presents frame-stable digits.
module score_ctl
  import game_pkg::*;
#(
  parameter int WIN_SCORE    = 9,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       ball_en,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] player1_score,
  output logic [3:0] player2_score,
  output logic [6:0] char_code_p1,
  output logic [6:0] char_code_p2
);

  localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
  localparam logic [7:0] PAUSE_L = 8'(PAUSE_FRAMES);

  game_state_t r_state, w_next_state;
  logic [3:0]  r_s1, r_s2, w_s1, w_s2;
  logic        r_serve, w_serve;
  logic        r_winner, w_winner;
  logic [7:0]  r_pcnt, w_pcnt;
  logic        r_ball_en, r_game_over;
  logic [3:0]  r_disp1, r_disp2;
  logic [6:0]  r_char1, r_char2;
  logic        w_tick;

  rise_det u_rise_det (
    .clk  (clk),
    .rst  (rst),
    .sig  (vblnk),
    .tick (w_tick)
  );

  // Next-state, score, serve and pause-counter decisions.
  always_comb begin
    w_next_state = r_state;
    w_s1         = r_s1;
    w_s2         = r_s2;
    w_serve      = r_serve;
    w_winner     = r_winner;
    w_pcnt       = r_pcnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = PAUSE;
          w_pcnt       = 8'd0;
        end else begin
          w_next_state = IDLE;
        end
      end
      PAUSE: begin
        if (w_tick) begin
          if (r_pcnt + 8'd1 == PAUSE_L) begin
            w_next_state = PLAY;
            w_pcnt       = 8'd0;
          end else begin
            w_pcnt = r_pcnt + 8'd1;
          end
        end else begin
          w_pcnt = r_pcnt;
        end
      end
      PLAY: begin
        if (goal_p1 && goal_p2) begin
          // Simultaneous goals: no point, re-serve in the same direction.
          w_next_state = PAUSE;
          w_pcnt       = 8'd0;
        end else if (goal_p1) begin
          w_s1    = r_s1 + 4'd1;
          w_serve = 1'b1;
          w_pcnt  = 8'd0;
          if (r_s1 + 4'd1 == WIN_L) begin
            w_next_state = OVER;
            w_winner     = 1'b0;
          end else begin
            w_next_state = PAUSE;
          end
        end else if (goal_p2) begin
          w_s2    = r_s2 + 4'd1;
          w_serve = 1'b0;
          w_pcnt  = 8'd0;
          if (r_s2 + 4'd1 == WIN_L) begin
            w_next_state = OVER;
            w_winner     = 1'b1;
          end else begin
            w_next_state = PAUSE;
          end
        end else begin
          w_next_state = PLAY;
        end
      end
      OVER: begin
        if (start) begin
          w_next_state = PAUSE;
          w_s1         = 4'd0;
          w_s2         = 4'd0;
          w_pcnt       = 8'd0;
        end else begin
          w_next_state = OVER;
        end
      end
      default: begin
        w_next_state = IDLE;
        w_pcnt       = 8'd0;
      end
    endcase
  end

  // State, internal scores, serve/winner and registered status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_s1        <= 4'd0;
      r_s2        <= 4'd0;
      r_serve     <= 1'b0;
      r_winner    <= 1'b0;
      r_pcnt      <= 8'd0;
      r_ball_en   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_serve     <= w_serve;
      r_winner    <= w_winner;
      r_pcnt      <= w_pcnt;
      r_ball_en   <= (w_next_state == PLAY);
      r_game_over <= (w_next_state == OVER);
    end
  end

  // Display copies change only on a frame tick so digits stay stable mid-frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_disp1 <= 4'd0;
      r_disp2 <= 4'd0;
      r_char1 <= ASCII_ZERO;
      r_char2 <= ASCII_ZERO;
    end else if (w_tick) begin
      r_disp1 <= r_s1;
      r_disp2 <= r_s2;
      r_char1 <= digit_char(r_s1);
      r_char2 <= digit_char(r_s2);
    end
  end

  assign ball_en       = r_ball_en;
  assign serve_dir     = r_serve;
  assign game_over     = r_game_over;
  assign winner        = r_winner;
  assign player1_score = r_disp1;
  assign player2_score = r_disp2;
  assign char_code_p1  = r_char1;
  assign char_code_p2  = r_char2;

endmodule

// File: tb/tb_score_ctl.sv
// Self-checking bench for score_ctl: directed table, hand sequences, random run.
module tb_score_ctl;

  localparam int WIN = 3;
  localparam int PF  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       vblnk = 1'b0, start = 1'b0, goal_p1 = 1'b0, goal_p2 = 1'b0;
  logic       ball_en, serve_dir, game_over, winner;
  logic [3:0] player1_score, player2_score;
  logic [6:0] char_code_p1, char_code_p2;

  score_ctl #(.WIN_SCORE(WIN), .PAUSE_FRAMES(PF)) dut (
    .clk(clk), .rst(rst), .vblnk(vblnk), .start(start),
    .goal_p1(goal_p1), .goal_p2(goal_p2),
    .ball_en(ball_en), .serve_dir(serve_dir), .game_over(game_over),
    .winner(winner), .player1_score(player1_score), .player2_score(player2_score),
    .char_code_p1(char_code_p1), .char_code_p2(char_code_p2)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the match is a phase plus point tallies and a frame countdown.
  int  m_phase;       // 0 waiting, 1 ball held, 2 rally, 3 finished
  int  m_left;        // frame ticks still to wait while held
  int  m_pts1, m_pts2, m_shown1, m_shown2;
  bit  m_serve, m_win, m_vb_prev;

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_pts1 = 0; m_pts2 = 0;
    m_shown1 = 0; m_shown2 = 0; m_serve = 0; m_win = 0; m_vb_prev = 0;
  endtask

  task automatic model_step(input bit vb, input bit st, input bit g1, input bit g2);
    bit tick;
    tick = vb && !m_vb_prev;
    m_vb_prev = vb;
    if (tick) begin
      m_shown1 = m_pts1;
      m_shown2 = m_pts2;
    end
    if (m_phase == 0) begin
      if (st) begin m_phase = 1; m_left = PF; end
    end else if (m_phase == 1) begin
      if (tick) begin
        m_left--;
        if (m_left == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      if (g1 && g2) begin
        m_phase = 1; m_left = PF;
      end else if (g1 || g2) begin
        if (g1) begin m_pts1++; m_serve = 1; end
        else    begin m_pts2++; m_serve = 0; end
        if (m_pts1 == WIN || m_pts2 == WIN) begin
          m_phase = 3; m_win = g2;
        end else begin
          m_phase = 1; m_left = PF;
        end
      end
    end else begin
      if (st) begin m_pts1 = 0; m_pts2 = 0; m_phase = 1; m_left = PF; end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("ball_en",   int'(ball_en),   int'(m_phase == 2));
    check("game_over", int'(game_over), int'(m_phase == 3));
    check("serve_dir", int'(serve_dir), int'(m_serve));
    if (m_phase == 3) check("winner", int'(winner), int'(m_win));
    check("p1_score", int'(player1_score), m_shown1);
    check("p2_score", int'(player2_score), m_shown2);
    check("char_p1", int'(char_code_p1), 'h30 + m_shown1);
    check("char_p2", int'(char_code_p2), 'h30 + m_shown2);
  endtask

  // One clock: drive at negedge, model follows the edge, compare at next negedge.
  task automatic cyc(input bit vb, input bit st, input bit g1, input bit g2);
    vblnk = vb; start = st; goal_p1 = g1; goal_p2 = g2;
    @(posedge clk);
    model_step(vb, st, g1, g2);
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_play();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    bit       vb, st, g1, g2;
    bit       e_ball, e_serve, e_over;
    bit [3:0] e_d1, e_d2;
  } vec_t;

  vec_t vecs[13];

  initial begin
    // vb st g1 g2 | ball serve over d1 d2
    vecs[0]  = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 4'd0,4'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 4'd0,4'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 4'd0,4'd0};
    vecs[3]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 4'd0,4'd0};
    vecs[4]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0, 4'd0,4'd0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd1,4'd0};
    vecs[6]  = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b1,1'b0, 4'd1,4'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 4'd1,4'd0};
    vecs[8]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 4'd1,4'd0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd1,4'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0, 4'd1,4'd0};
    vecs[11] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b0, 4'd1,4'd0};
    vecs[12] = '{1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0, 4'd1,4'd0};

    // Reset state
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_winner", int'(winner), 0);
    compare_all();
    rst = 1'b1;
    @(negedge clk);
    compare_all();

    // Directed table
    for (int i = 0; i < 13; i++) begin
      cyc(vecs[i].vb, vecs[i].st, vecs[i].g1, vecs[i].g2);
      check("tbl_ball",  int'(ball_en),       int'(vecs[i].e_ball));
      check("tbl_serve", int'(serve_dir),     int'(vecs[i].e_serve));
      check("tbl_over",  int'(game_over),     int'(vecs[i].e_over));
      check("tbl_d1",    int'(player1_score), int'(vecs[i].e_d1));
      check("tbl_d2",    int'(player2_score), int'(vecs[i].e_d2));
    end

    // Player 2 wins: s2 was 1, two more goals end the match
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    to_play();
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    check("over_flag", int'(game_over), 1);
    check("over_winner", int'(winner), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);   // ignored in OVER
    cyc(1'b1, 1'b0, 1'b0, 1'b0);   // tick shows final score
    check("final_p2", int'(player2_score), 3);
    check("final_p1", int'(player1_score), 1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);   // restart clears scores
    check("restart_over", int'(game_over), 0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);   // goals during PAUSE ignored, tick shows zeros
    check("restart_p2", int'(player2_score), 0);
    check("restart_c2", int'(char_code_p2), 'h30);

    // Async reset mid-rally with s1 = 2
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    to_play();
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    to_play();
    check("pre_rst_ball", int'(ball_en), 1);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("arst_winner", int'(winner), 0);
    compare_all();
    @(negedge clk);
    rst = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0);   // goal in IDLE ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_p1", int'(player1_score), 0);

    // Randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      bit vb_r, st_r, g1_r, g2_r;
      vb_r = ($urandom_range(0, 3) == 0) ? !vblnk : vblnk;
      st_r = ($urandom_range(0, 29) == 0);
      g1_r = ($urandom_range(0, 5) == 0);
      g2_r = ($urandom_range(0, 5) == 0);
      cyc(vb_r, st_r, g1_r, g2_r);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_ctl.md
# score_ctl

Game-level score controller for the pong display path. Sequences a match from serve to game over, counts points for both players from goal pulses, holds the ball still between points, and presents frame-stable scores and ASCII character codes to the score text overlay. It sits between the ball/collision logic, which produces goals and consumes the ball enable, and the score drawing stage, which consumes the character codes.

## Interface
Parameters:
- WIN_SCORE, 9: points that end the match; legal range 1..9, so the score is always one digit.
- PAUSE_FRAMES, 60: whole frames the ball is held between points; legal range 1..255.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- vblnk  in  1  vertical blanking from the VGA timing chain.
- start  in  1  one-cycle pulse from the debounced start button.
- goal_p1  in  1  one-cycle pulse: player 1 scored.
- goal_p2  in  1  one-cycle pulse: player 2 scored.
- ball_en  out  1  ball motion enable.
- serve_dir  out  1  0 = serve toward player 1, 1 = serve toward player 2.
- game_over  out  1  high while the match is finished.
- winner  out  1  0 = player 1, 1 = player 2; meaningful only while game_over is high.
- player1_score  out  4  display copy of the player 1 score.
- player2_score  out  4  display copy of the player 2 score.
- char_code_p1  out  7  ASCII digit for player 1: 'h30 + player1_score.
- char_code_p2  out  7  ASCII digit for player 2: 'h30 + player2_score.

## Operation
- States: IDLE, PAUSE, PLAY, OVER.
  - Reset enters IDLE.
  - In IDLE, start moves to PAUSE.
  - PAUSE moves to PLAY once PAUSE_FRAMES frame ticks have been counted.
  - In PLAY, a goal moves to PAUSE, or to OVER when the new score equals WIN_SCORE.
  - In OVER, start clears both scores and moves to PAUSE.
- ball_en is 1 only in PLAY. game_over is 1 only in OVER.
- Frame tick: vblnk high while the registered vblnk is low.
- Internal scores s1 and s2 are 4 bits wide. Each increments by exactly 1 and never exceeds WIN_SCORE.
- A goal is accepted only in PLAY. Goal pulses in IDLE, PAUSE or OVER are ignored.
- goal_p1 alone:
  - s1 increments; serve_dir becomes 1.
  - If s1+1 equals WIN_SCORE, go to OVER with winner = 0.
- goal_p2 alone: the mirror case. s2 increments, serve_dir becomes 0, winner = 1.
- goal_p1 and goal_p2 in the same cycle:
  - No point is awarded and serve_dir is unchanged.
  - The controller enters PAUSE for a re-serve.
- Pause counter:
  - Loads 0 on every entry to PAUSE.
  - Increments on each frame tick.
  - Leaves PAUSE on the tick that brings it to PAUSE_FRAMES.
- start while in PAUSE or PLAY is ignored.
- Display copies player1_score and player2_score load from s1 and s2 only on a frame tick, so a digit never changes mid-frame. char_code outputs are derived from the display copies.

## Timing
- Reset values:
  - State IDLE; s1, s2 and both display scores 0.
  - char_code_p1 and char_code_p2 'h30.
  - ball_en, serve_dir, game_over and winner all 0.
  - Pause counter 0; registered vblnk 0.
- Reset asserted mid-match clears everything asynchronously, regardless of state.
- All outputs are registered.
- A goal sampled at edge n: s1/s2, state, serve_dir, winner and game_over are updated at edge n, visible after edge n. ball_en is low from edge n onward.
- Display scores and char codes update at the first frame tick edge after the internal change.
- PAUSE length: exactly PAUSE_FRAMES frame ticks. If vblnk is already high on entry, no tick is counted until the next rising edge.
- A start pulse at edge n in IDLE or OVER: the state changes at edge n. In OVER, the scores clear at the same edge.

## Structure
- Shared package game_pkg holds:
  - typedef enum logic [1:0] game_state_t {IDLE, PAUSE, PLAY, OVER}
  - localparam ASCII_ZERO = 7'h30
- Sub-module rise_det detects the vblnk rising edge to produce the frame tick. It is clocked by clk with the same asynchronous active-low reset.
- The rest is one FSM block plus the score registers and the pause counter.

## Test plan
- Reset, start pulse, then 2 frames (parameters WIN_SCORE=3, PAUSE_FRAMES=2) -> ball_en rises on the 2nd tick; scores 0, char codes 'h30.
- In PLAY, goal_p1 -> s1=1 and serve_dir=1 at the next edge; ball_en drops; char_code_p1 becomes 'h31 only at the next vblnk rise.
- goal_p1 and goal_p2 in the same cycle -> both scores unchanged; serve_dir unchanged; PAUSE entered.
- With WIN_SCORE=3, goal_p2 three times -> game_over=1, winner=1, player2_score=3; a further goal_p1 is ignored; start -> scores 0, PAUSE.
- Goal pulses during PAUSE and IDLE -> no score change.
- rst asserted asynchronously mid-PLAY with s1=2 -> all outputs at reset values immediately; IDLE after release.
